// File: rtl/pixel_pkg.sv
// Shared types and default sizing for the Mandelbrot pixel merge path.
// Each pixel result carries its x coordinate and the escape iteration depth.
package pixel_pkg;

  localparam int X_WIDTH         = 10;
  localparam int DEPTH_WIDTH     = 10;
  localparam int DATA_WIDTH_DEF  = X_WIDTH + DEPTH_WIDTH;
  localparam int DEPTH_DEF       = 64;
  localparam int NUM_ENGINES_DEF = 5;

  typedef struct packed {
    logic [X_WIDTH-1:0]     x;
    logic [DEPTH_WIDTH-1:0] depth;
  } pixel_t;

  // Occupancy counters must be able to hold the value DEPTH itself.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rr_space_arbiter.sv
// Rotating-priority write arbiter: grants valid engines in scan order from
// i_rr_ptr until the free space runs out, and assigns each a storage offset.
module rr_space_arbiter
  import pixel_pkg::*;
#(
  parameter int NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int CNT_W       = count_width(DEPTH_DEF),
  localparam int PTR_W      = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
  input  logic [NUM_ENGINES-1:0]       i_wr_valid,
  input  logic [CNT_W-1:0]             i_free,
  input  logic [PTR_W-1:0]             i_rr_ptr,
  output logic [NUM_ENGINES-1:0]       o_grant,
  output logic [NUM_ENGINES*CNT_W-1:0] o_offsets,
  output logic [CNT_W-1:0]             o_grant_cnt
);

  // Walk the ports once in rotated order; the running grant count doubles as
  // the offset from the write pointer at which each granted word is stored.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    o_grant   = '0;
    o_offsets = '0;
    cnt       = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      sum = {1'b0, i_rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_ENGINES)) begin
        sum = sum - (PTR_W+1)'(NUM_ENGINES);
      end
      idx = sum[PTR_W-1:0];
      if (i_wr_valid[idx] && (cnt < i_free)) begin
        o_grant[idx]                   = 1'b1;
        o_offsets[CNT_W*idx +: CNT_W] = cnt;
        cnt                            = cnt + 1'b1;
      end
    end
    o_grant_cnt = cnt;
  end

endmodule

// File: rtl/pixel_merge_fifo.sv
// Many-to-one FIFO merging pixel results from several engines into one ordered
// stream, with rotating write priority and an FWFT or registered read port.
module pixel_merge_fifo
  import pixel_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int NUM_ENGINES    = NUM_ENGINES_DEF,
  parameter int FWFT           = 1,
  parameter int ALMOST_FULL_TH = 56,
  localparam int CNT_W         = count_width(DEPTH),
  localparam int ADDR_W        = $clog2(DEPTH),
  localparam int PTR_W         = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [DATA_WIDTH*NUM_ENGINES-1:0] wr_data,
  input  logic [NUM_ENGINES-1:0]            wr_valid,
  output logic [NUM_ENGINES-1:0]            wr_ready,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic [CNT_W-1:0]                  count,
  output logic                              almost_full,
  output logic                              empty,
  output logic                              err_sticky
);

  logic [DATA_WIDTH-1:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0]            r_wr_ptr;
  logic [ADDR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]             r_count;
  logic [PTR_W-1:0]             r_rr_ptr;
  logic                         r_err;

  logic [NUM_ENGINES-1:0]       w_grant;
  logic [NUM_ENGINES*CNT_W-1:0] w_offsets;
  logic [CNT_W-1:0]             w_grant_cnt;
  logic [CNT_W-1:0]             w_free;
  logic [PTR_W-1:0]             w_next_rr;
  logic                         w_empty;
  logic                         w_pop;
  logic                         w_denied;
  logic                         w_err_set;

  // Space comes from the registered count only, so rd_ready never reaches wr_ready.
  assign w_free   = CNT_W'(DEPTH) - r_count;
  assign w_empty  = (r_count == '0);
  assign w_pop    = rd_ready & ~w_empty;
  assign w_denied = |(wr_valid & ~w_grant);

  rr_space_arbiter #(
    .NUM_ENGINES (NUM_ENGINES),
    .CNT_W       (CNT_W)
  ) u_arbiter (
    .i_wr_valid  (wr_valid),
    .i_free      (w_free),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_offsets   (w_offsets),
    .o_grant_cnt (w_grant_cnt)
  );

  assign wr_ready    = w_grant & {NUM_ENGINES{reset_n}};
  assign count       = r_count;
  assign empty       = w_empty;
  assign almost_full = (r_count >= CNT_W'(ALMOST_FULL_TH));
  assign err_sticky  = r_err;

  // The last granted port is the one holding the highest offset.
  always_comb begin
    w_next_rr = r_rr_ptr;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (w_grant[i] && (w_offsets[CNT_W*i +: CNT_W] == w_grant_cnt - 1'b1)) begin
        w_next_rr = (i == NUM_ENGINES - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (w_grant[i]) begin
        r_mem[r_wr_ptr + w_offsets[CNT_W*i +: ADDR_W]] <= wr_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_grant_cnt[ADDR_W-1:0];
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + w_grant_cnt - CNT_W'(w_pop);
      if (w_denied && (w_grant_cnt != '0)) begin
        r_rr_ptr <= w_next_rr;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_valid  = ~w_empty;
      assign rd_data   = w_empty ? '0 : r_mem[r_rd_ptr];
      assign w_err_set = 1'b0;
    end else begin : g_registered
      logic                  r_rd_valid;
      logic [DATA_WIDTH-1:0] r_rd_data;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else begin
          r_rd_valid <= w_pop;
          if (w_pop) begin
            r_rd_data <= r_mem[r_rd_ptr];
          end
        end
      end

      assign rd_valid  = r_rd_valid;
      assign rd_data   = r_rd_data;
      assign w_err_set = rd_ready & w_empty;
    end
  endgenerate

endmodule
